// File: rtl/transport_up_pkg.sv
// Shared types and helpers for the PAICore upstream transport path.
package transport_up_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRecv,
        StEof,
        StWait,
        StHold
    } state_e;

    localparam int unsigned FrameCntW = 32;
    localparam logic        EofLast   = 1'b1;

    // Bits needed to hold values 0..max_val inclusive.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO; head entry is visible whenever not empty.
module sync_fifo_fwft #(
    parameter int unsigned WIDTH = 65,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AddrW = $clog2(DEPTH);
    localparam int unsigned CntW  = AddrW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_wr, do_rd;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CntW'(DEPTH));
    assign count_o = count_q;

    // A pop frees the slot in the same cycle, so a full FIFO still accepts a write then.
    assign do_rd = rd_en_i & ~empty_o;
    assign do_wr = wr_en_i & (~full_o | do_rd);

    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        unique case ({do_wr, do_rd})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + AddrW'(1);
            if (do_rd) rd_ptr_q <= rd_ptr_q + AddrW'(1);
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/transport_up_buffered.sv
// PAICore -> AXI-Stream upstream path with FWFT buffering, done detection and EOF framing.
// Optional watchdog-forced EOF is built when TRANSPORT_UP_TIMEOUT_EN is defined.
module transport_up_buffered
    import transport_up_pkg::*;
#(
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned AF_MARGIN   = 2,
    parameter int unsigned DONE_CNT    = 200,
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic                 s_axis_aclk,
    input  logic                 s_axis_aresetn,
    input  logic                 i_rx_rcving,
    output logic                 o_recv_available,
    input  logic                 i_recv_valid,
    input  logic [DATA_W-1:0]    i_recv_tdata,
    input  logic                 i_recv_done,
    input  logic                 i_recv_busy,
    input  logic                 m_axis_tready,
    output logic [DATA_W-1:0]    m_axis_tdata,
    output logic                 m_axis_tvalid,
    output logic                 m_axis_tlast,
    output logic                 m_axis_hsked,
    output logic                 o_rx_done,
    output logic [FrameCntW-1:0] o_frame_cnt,
    output logic                 o_overflow,
    output logic                 o_timeout
);

    localparam int unsigned CntW  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned DoneW = cnt_width(DONE_CNT);
    localparam logic [DATA_W:0] EofEntry = {EofLast, {DATA_W{1'b1}}};

    state_e               state_q, state_d;
    logic [DoneW-1:0]     done_cnt_q, done_cnt_d;
    logic                 avail_q, rx_done_q, overflow_q;
    logic [FrameCntW-1:0] frame_cnt_q;

    logic                 fifo_full, fifo_empty, fifo_wr;
    logic [CntW-1:0]      fifo_count, fifo_free;
    logic [DATA_W:0]      fifo_wr_data, fifo_rd_data;
    logic                 core_push, eof_push, hsked, eof_hsked;
    logic                 done_qual, done_hit, wd_hit;

    assign core_push    = i_rx_rcving & i_recv_valid & (state_q == StRecv);
    assign eof_push     = (state_q == StEof) & ~fifo_full;
    assign fifo_wr      = core_push | eof_push;
    assign fifo_wr_data = eof_push ? EofEntry : {1'b0, i_recv_tdata};
    assign fifo_free    = CntW'(FIFO_DEPTH) - fifo_count;

    sync_fifo_fwft #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (s_axis_aclk),
        .rst_ni    (s_axis_aresetn),
        .wr_en_i   (fifo_wr),
        .wr_data_i (fifo_wr_data),
        .rd_en_i   (m_axis_tready),
        .rd_data_o (fifo_rd_data),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    assign m_axis_tvalid = ~fifo_empty;
    assign {m_axis_tlast, m_axis_tdata} = fifo_rd_data;
    assign hsked         = m_axis_tvalid & m_axis_tready;
    assign m_axis_hsked  = hsked;
    assign eof_hsked     = (state_q == StWait) & hsked & m_axis_tlast;

    assign done_qual = (state_q == StRecv) & i_recv_done & ~i_recv_busy & ~i_recv_valid;
    assign done_hit  = (done_cnt_q == DoneW'(DONE_CNT));

    always_comb begin
        done_cnt_d = '0;
        if (done_qual) begin
            done_cnt_d = done_hit ? done_cnt_q : done_cnt_q + DoneW'(1);
        end
    end

`ifdef TRANSPORT_UP_TIMEOUT_EN
    localparam int unsigned WdW = cnt_width(TIMEOUT_CYC);
    logic [WdW-1:0] wd_q, wd_d;
    logic           timeout_q;

    assign wd_hit = (wd_q == WdW'(TIMEOUT_CYC));

    always_comb begin
        wd_d = '0;
        if ((state_q == StRecv) && !core_push && !done_qual) begin
            wd_d = wd_hit ? wd_q : wd_q + WdW'(1);
        end
    end

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q <= wd_d;
            if ((state_q == StRecv) && i_rx_rcving && wd_hit && !done_hit) timeout_q <= 1'b1;
        end
    end

    assign o_timeout = timeout_q;
`else
    logic unused_timeout_cyc;
    assign unused_timeout_cyc = ^TIMEOUT_CYC;
    assign wd_hit    = 1'b0;
    assign o_timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (i_rx_rcving) state_d = StRecv;
            StRecv: begin
                if (!i_rx_rcving)          state_d = StIdle;
                else if (done_hit || wd_hit) state_d = StEof;
            end
            StEof:  if (!fifo_full) state_d = StWait;
            StWait: if (eof_hsked)  state_d = StHold;
            // Stay here until the window closes so a lingering done cannot frame twice.
            StHold: if (!i_rx_rcving) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            state_q     <= StIdle;
            done_cnt_q  <= '0;
            avail_q     <= 1'b0;
            rx_done_q   <= 1'b0;
            frame_cnt_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            done_cnt_q <= done_cnt_d;
            // Margin absorbs the one-cycle lag between this flag and the core reacting.
            avail_q    <= i_rx_rcving & (state_q == StRecv) & (fifo_free > CntW'(AF_MARGIN));
            rx_done_q  <= eof_hsked;
            if (eof_hsked) frame_cnt_q <= frame_cnt_q + FrameCntW'(1);
            if (core_push && fifo_full && !hsked) overflow_q <= 1'b1;
        end
    end

    assign o_recv_available = avail_q;
    assign o_rx_done        = rx_done_q;
    assign o_frame_cnt      = frame_cnt_q;
    assign o_overflow       = overflow_q;

endmodule
